fifo_burst_reader: RTL and testbench

- Read-side engine for the team's synchronous 32-bit FIFO.
- Pops an exact burst of words through the FIFO's read_en/data_out/empty interface, absorbing the FIFO's one-cycle registered read latency.
- Re-presents the words on a valid/ready stream with last-word marking and a done pulse.
- Sits between the FIFO and any downstream consumer (DMA, serializer) that may stall.

---
 rtl/fifo_burst_reader_if.sv | 30 +++
 rtl/fifo_burst_reader.sv | 130 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its controller, the FIFO read port and the
// downstream stream consumer.
interface fifo_burst_reader_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LenWidth  = 16
);
    logic                 start;
    logic [LenWidth-1:0]  burst_len;
    logic                 fifo_empty;
    logic [DataWidth-1:0] fifo_data;
    logic                 fifo_rd_en;
    logic                 m_valid;
    logic [DataWidth-1:0] m_data;
    logic                 m_last;
    logic                 m_ready;
    logic                 busy;
    logic                 done;

    // Reader side: consumes control, FIFO data and downstream ready.
    modport master (
        input  start, burst_len, fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, busy, done
    );

    // Environment side: controller, FIFO and consumer.
    modport slave (
        output start, burst_len, fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read engine: pops exactly burst_len words from a synchronous FIFO with a one-cycle
// registered read latency and re-presents them on a valid/ready stream with last marking.
module fifo_burst_reader #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    fifo_burst_reader_if.master io_bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [LenWidth-1:0] LenOne = LenWidth'(1);

    state_e               r_state;
    state_e               w_state_next;
    logic [LenWidth-1:0]  r_len;
    logic [LenWidth-1:0]  r_issue_cnt;
    logic [LenWidth-1:0]  r_deliver_cnt;
    logic                 r_inflight;
    logic [1:0]           r_occ;
    logic [DataWidth-1:0] r_buf0;
    logic [DataWidth-1:0] r_buf1;

    logic                 w_pop;
    logic                 w_rd_en;
    logic                 w_last_pop;
    logic [2:0]           w_outstanding;

    assign w_pop         = (r_occ != 2'd0) && io_bus.m_ready;
    assign w_outstanding = {1'b0, r_occ} + {2'b00, r_inflight};
    // occ + inflight - pop < 2, with pop moved to the right to stay unsigned
    assign w_rd_en       = (r_state == StRun) && !io_bus.fifo_empty &&
                           (r_issue_cnt < r_len) &&
                           (w_outstanding < (3'd2 + {2'b00, w_pop}));
    assign w_last_pop    = w_pop && (r_deliver_cnt == (r_len - LenOne));

    // Next-state decode for the burst sequencer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_state_next = (io_bus.burst_len != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (w_last_pop) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst length latch and issue/deliver counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len         <= '0;
            r_issue_cnt   <= '0;
            r_deliver_cnt <= '0;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if ((r_state == StIdle) && io_bus.start) begin
                r_len         <= io_bus.burst_len;
                r_issue_cnt   <= '0;
                r_deliver_cnt <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issue_cnt <= r_issue_cnt + LenOne;
                end
                if (w_pop) begin
                    r_deliver_cnt <= r_deliver_cnt + LenOne;
                end
            end
        end
    end

    // Two-entry output buffer; r_buf0 is always the head presented downstream.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            unique case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= io_bus.fifo_data;
                    end else begin
                        r_buf1 <= io_bus.fifo_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_buf0 <= io_bus.fifo_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= io_bus.fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.fifo_rd_en = w_rd_en;
    assign io_bus.m_valid    = (r_occ != 2'd0);
    assign io_bus.m_data     = r_buf0;
    assign io_bus.m_last     = (r_occ != 2'd0) && (r_deliver_cnt == (r_len - LenOne));
    assign io_bus.busy       = (r_state == StRun);
    assign io_bus.done       = (r_state == StDone);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT, and a word-level
// scoreboard predicts stream contents, timing and control outputs every cycle.
module tb_fifo_burst_reader;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DataWidth(DW), .LenWidth(LW)) bus ();

    fifo_burst_reader #(.DataWidth(DW), .LenWidth(LW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } word_t;

    typedef struct {
        int            len;
        int            preload;
        logic [DW-1:0] base;
        int            stall;
        int            exp_stall_rd;
        int            exp_done_lat;
        int            exp_left;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [DW-1:0] fq[$];
    word_t         exp_q[$];
    logic [DW-1:0] deliv_log[$];
    int            phase, m_len, n_iss, n_del, done_cnt;
    logic          s_rd, s_done, s_valid;
    vec_t          vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_refresh();
    endtask

    // Word-level reference: every word popped from the FIFO must appear on the stream in
    // order, no earlier than two cycles after its read strobe and as soon as that allows.
    task automatic monitor();
        logic rd, exp_v, pop, exp_rd;
        int   nph;
        rd      = bus.fifo_rd_en;
        s_rd    = rd;
        s_done  = bus.done;
        s_valid = bus.m_valid;
        if (bus.done) done_cnt++;
        chk("rd_en_while_empty", rd && bus.fifo_empty, 1'b0);
        chk("busy", bus.busy, phase == 1);
        chk("done", bus.done, phase == 2);
        exp_v = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        chk("m_valid", bus.m_valid, exp_v);
        if (exp_v) begin
            chk("m_data", bus.m_data, exp_q[0].data);
            chk("m_last", bus.m_last, n_del == m_len - 1);
        end else begin
            chk("m_last_no_word", bus.m_last, 1'b0);
        end
        pop    = exp_v && bus.m_ready;
        exp_rd = (phase == 1) && !bus.fifo_empty && (n_iss < m_len) &&
                 ((n_iss - n_del - int'(pop)) < 2);
        chk("fifo_rd_en", rd, exp_rd);
        if (rst) begin
            phase = 0; m_len = 0; n_iss = 0; n_del = 0;
            exp_q.delete();
            return;
        end
        if (rd && fq.size() > 0) begin
            exp_q.push_back('{data: fq[0], avail: cyc + 2});
            n_iss++;
        end
        if (pop) begin
            deliv_log.push_back(exp_q[0].data);
            void'(exp_q.pop_front());
            n_del++;
        end
        nph = phase;
        case (phase)
            0: if (bus.start) begin
                if (bus.burst_len != 0) begin
                    nph = 1; m_len = int'(bus.burst_len); n_iss = 0; n_del = 0;
                end else begin
                    nph = 2;
                end
            end
            1: if (pop && n_del == m_len) nph = 2;
            default: nph = 0;
        endcase
        phase = nph;
    endtask

    // One clock: sample/check at the falling edge, then advance the FIFO model after the
    // rising edge (registered read data appears one cycle after the strobe).
    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        if (s_rd && fq.size() > 0) bus.fifo_data = fq.pop_front();
        fifo_refresh();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, bus.fifo_rd_en, 1'b0);
        chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
        chk({tag, "_m_data"}, bus.m_data, '0);
        chk({tag, "_m_last"}, bus.m_last, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int start_cyc, rel, lat, stall_rd;
        fq.delete();
        for (int i = 0; i < v.preload; i++) fq.push_back(v.base + DW'(i));
        fifo_refresh();
        done_cnt = 0;
        deliv_log.delete();
        bus.burst_len = LW'(v.len);
        bus.start     = 1'b1;
        bus.m_ready   = (v.stall == 0);
        start_cyc     = cyc + 1;
        lat           = -1;
        stall_rd      = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            bus.start = 1'b0;
            rel = cyc - start_cyc;
            if (s_rd && rel < v.stall) stall_rd++;
            bus.m_ready = (rel + 1 >= v.stall);
            if (s_done) begin
                lat = rel;
                break;
            end
        end
        chk("vec_done_latency", lat, v.exp_done_lat);
        chk("vec_stall_reads", stall_rd, v.exp_stall_rd);
        tick();
        chk("vec_done_count", done_cnt, 1);
        chk("vec_fifo_left", fq.size(), v.exp_left);
        chk("vec_words", deliv_log.size(), v.len);
        for (int i = 0; i < deliv_log.size(); i++) begin
            chk("vec_order", deliv_log[i], v.base + DW'(i));
        end
    endtask

    initial begin
        int            start_cyc, rel, early_rd, len, pre, pushed;
        bit            seen;
        logic [DW-1:0] pushed_q[$];

        // len, preload, base, stall, rd during stall, done latency, words left in FIFO
        vecs[0] = '{4, 4, 32'h0000_00A0, 0,  0, 7,  0};
        vecs[1] = '{6, 6, 32'h0000_0B00, 10, 2, 16, 0};
        vecs[2] = '{0, 3, 32'h0000_0C00, 0,  0, 1,  3};
        vecs[3] = '{1, 2, 32'h0000_0D00, 5,  1, 6,  1};
        vecs[4] = '{3, 5, 32'h0000_0E00, 2,  1, 6,  2};
        vecs[5] = '{2, 2, 32'h0000_0F00, 3,  2, 5,  0};

        rst = 1'b1;
        bus.start = 1'b0; bus.burst_len = '0; bus.m_ready = 1'b0; bus.fifo_data = '0;
        phase = 0; m_len = 0; n_iss = 0; n_del = 0; done_cnt = 0;
        fifo_refresh();
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // FIFO empty at start; words trickle in at cycles 5 and 12.
        fq.delete(); fifo_refresh();
        done_cnt = 0; deliv_log.delete();
        bus.m_ready = 1'b1; bus.burst_len = LW'(3); bus.start = 1'b1;
        start_cyc = cyc + 1; early_rd = 0; seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            bus.start = 1'b0;
            rel = cyc - start_cyc;
            if (s_rd && rel < 5) early_rd++;
            if (rel == 4) push(32'h11);
            if (rel == 11) begin
                push(32'h22);
                push(32'h33);
            end
            if (s_done) seen = 1;
        end
        chk("empty_done_seen", seen, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        chk("empty_early_rd", early_rd, 0);
        chk("empty_done_count", done_cnt, 1);
        chk("empty_words", deliv_log.size(), 3);
        if (deliv_log.size() == 3) begin
            chk("empty_w0", deliv_log[0], 32'h11);
            chk("empty_w1", deliv_log[1], 32'h22);
            chk("empty_w2", deliv_log[2], 32'h33);
        end

        // Reset while one word is buffered and one is in flight.
        fq.delete();
        for (int i = 0; i < 6; i++) fq.push_back(32'hB0 + DW'(i));
        fifo_refresh();
        bus.m_ready = 1'b0; bus.burst_len = LW'(4); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("pre_reset_valid", s_valid, 1'b1);
        rst = 1'b0;
        check_all_zero("mid_reset");
        done_cnt = 0; deliv_log.delete();
        bus.m_ready = 1'b1; bus.burst_len = LW'(2); bus.start = 1'b1;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            bus.start = 1'b0;
            if (s_done) seen = 1;
        end
        tick();
        chk("post_reset_done", done_cnt, 1);
        chk("post_reset_words", deliv_log.size(), 2);
        if (deliv_log.size() == 2) begin
            chk("post_reset_w0", deliv_log[0], 32'hB2);
            chk("post_reset_w1", deliv_log[1], 32'hB3);
        end
        chk("post_reset_left", fq.size(), 2);

        // A second start during an active burst must be ignored.
        fq.delete();
        for (int i = 0; i < 12; i++) fq.push_back(32'hC0 + DW'(i));
        fifo_refresh();
        done_cnt = 0; deliv_log.delete();
        bus.m_ready = 1'b1; bus.burst_len = LW'(8); bus.start = 1'b1;
        start_cyc = cyc + 1; seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            rel = cyc - start_cyc;
            bus.start = (rel == 3);
            if (rel == 3) bus.burst_len = LW'(3);
            if (s_done) seen = 1;
        end
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("restart_done_count", done_cnt, 1);
        chk("restart_words", deliv_log.size(), 8);
        for (int i = 0; i < deliv_log.size(); i++) chk("restart_order", deliv_log[i],
                                                        32'hC0 + DW'(i));
        chk("restart_left", fq.size(), 4);

        // Randomized bursts with random backpressure and FIFO refill.
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(0, 12);
            pre = $urandom_range(0, len);
            fq.delete(); pushed_q.delete();
            for (int i = 0; i < pre; i++) begin
                pushed_q.push_back($urandom);
                fq.push_back(pushed_q[i]);
            end
            pushed = pre;
            fifo_refresh();
            done_cnt = 0; deliv_log.delete();
            bus.burst_len = LW'(len); bus.start = 1'b1;
            bus.m_ready = ($urandom_range(0, 9) < 7);
            seen = 0;
            for (int k = 0; k < 600 && !seen; k++) begin
                tick();
                bus.start = 1'b0;
                if (s_done) seen = 1;
                bus.m_ready = ($urandom_range(0, 9) < 7);
                if (!seen && pushed < len + 2 && $urandom_range(0, 2) == 0) begin
                    pushed_q.push_back($urandom);
                    push(pushed_q[pushed]);
                    pushed++;
                end
            end
            chk("rnd_done_seen", seen, 1'b1);
            tick();
            chk("rnd_done_count", done_cnt, 1);
            chk("rnd_words", deliv_log.size(), len);
            for (int i = 0; i < deliv_log.size() && i < pushed; i++) begin
                chk("rnd_order", deliv_log[i], pushed_q[i]);
            end
            chk("rnd_fifo_left", fq.size(), pushed - len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
